// File: rtl/traffic_pkg.sv
// Shared types and helpers for the traffic light controller.
// Sensor lanes use them to debounce and count arrivals.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    CHECK_HIGH = 2'd1,
    IDLE_HIGH  = 2'd2,
    CHECK_LOW  = 2'd3
  } sensor_state_t;

  localparam logic [7:0] ARRIVAL_MAX = 8'd255;

  // Stable-time requirement in clock cycles, never less than one cycle.
  function automatic int debounce_cycles(input int clk_per, input int debounce_ns);
    int q;
    q = debounce_ns / clk_per;
    return (q < 1) ? 1 : q;
  endfunction

endpackage

// File: rtl/sensor_lane.sv
// One sensor lane: two-flop synchronizer, debounce FSM, sticky request flop
// and saturating arrival counter.
module sensor_lane
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw,
  input  logic       ack,
  output logic       level,
  output logic       request,
  output logic [7:0] arrivals
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_reg, s2_reg;
  sensor_state_t    state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_reg, level_next;
  logic             request_reg, request_next;
  logic [7:0]       arrivals_reg, arrivals_next;
  logic             rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_reg       <= 1'b0;
      s2_reg       <= 1'b0;
      state_reg    <= IDLE_LOW;
      cnt_reg      <= '0;
      level_reg    <= 1'b0;
      request_reg  <= 1'b0;
      arrivals_reg <= '0;
    end else begin
      s1_reg       <= sw;
      s2_reg       <= s1_reg;
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      level_reg    <= level_next;
      request_reg  <= request_next;
      arrivals_reg <= arrivals_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    level_next = level_reg;
    rise       = 1'b0;
    unique case (state_reg)
      IDLE_LOW: begin
        if (s2_reg) begin
          state_next = CHECK_HIGH;
          cnt_next   = '0;
        end
      end
      CHECK_HIGH: begin
        if (!s2_reg) begin
          state_next = IDLE_LOW;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_TERM) begin
          state_next = IDLE_HIGH;
          level_next = 1'b1;
          rise       = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!s2_reg) begin
          state_next = CHECK_LOW;
          cnt_next   = '0;
        end
      end
      CHECK_LOW: begin
        if (s2_reg) begin
          state_next = IDLE_HIGH;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_TERM) begin
          state_next = IDLE_LOW;
          level_next = 1'b0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE_LOW;
    endcase
  end

  // A new arrival beats a same-cycle acknowledge so no car is dropped.
  always_comb begin
    request_next  = request_reg;
    arrivals_next = arrivals_reg;
    if (rise) begin
      request_next = 1'b1;
      if (arrivals_reg != ARRIVAL_MAX)
        arrivals_next = arrivals_reg + 8'd1;
    end else if (ack) begin
      request_next = 1'b0;
    end
  end

  assign level    = level_reg;
  assign request  = request_reg;
  assign arrivals = arrivals_reg;

endmodule

// File: rtl/lane_sensor_conditioner.sv
// Conditions raw vehicle-sensor switches into debounced levels, sticky
// requests and per-lane arrival counts; one sensor_lane per input.
module lane_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int CLK_PER     = 10,
  parameter int DEBOUNCE_NS = 20000000,
  parameter int NUM_LANES   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_LANES-1:0]   SW,
  input  logic [NUM_LANES-1:0]   ack,
  output logic [NUM_LANES-1:0]   level,
  output logic [NUM_LANES-1:0]   request,
  output logic [8*NUM_LANES-1:0] arrivals
);

  localparam int DEBOUNCE_CYCLES = debounce_cycles(CLK_PER, DEBOUNCE_NS);

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      sensor_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_lane (
        .clk      (clk),
        .rst      (rst),
        .sw       (SW[gi]),
        .ack      (ack[gi]),
        .level    (level[gi]),
        .request  (request[gi]),
        .arrivals (arrivals[8*gi +: 8])
      );
    end
  endgenerate

endmodule

// File: tb/tb_lane_sensor_conditioner.sv
// Directed bench for lane_sensor_conditioner with DEBOUNCE_CYCLES = 4.
module tb_lane_sensor_conditioner;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  SW;
  logic [1:0]  ack;
  logic [1:0]  level;
  logic [1:0]  request;
  logic [15:0] arrivals;

  int total = 0;
  int bad   = 0;

  lane_sensor_conditioner #(
    .CLK_PER(10),
    .DEBOUNCE_NS(40),
    .NUM_LANES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .SW       (SW),
    .ack      (ack),
    .level    (level),
    .request  (request),
    .arrivals (arrivals)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press0_cycle();
    SW[0] = 1'b1;
    tick(7);
    SW[0] = 1'b0;
    tick(7);
  endtask

  initial begin
    rst = 1'b1;
    SW  = 2'b00;
    ack = 2'b00;
    tick(3);
    chk("reset_level", level, 0);
    chk("reset_request", request, 0);
    chk("reset_arrivals", arrivals, 0);
    rst = 1'b0;
    tick(2);

    // 1. clean press on lane 0
    SW[0] = 1'b1;
    tick(6);
    chk("press_edge6_level0", level[0], 0);
    chk("press_edge6_req0", request[0], 0);
    tick(1);
    chk("press_edge7_level0", level[0], 1);
    chk("press_edge7_req0", request[0], 1);
    chk("press_arr0", arrivals[7:0], 1);
    chk("press_lane1_untouched", {level[1], request[1]}, 0);
    chk("press_arr1", arrivals[15:8], 0);

    // 2. bouncy lane 1
    SW[1] = 1'b1; tick(3);
    SW[1] = 1'b0; tick(2);
    SW[1] = 1'b1; tick(3);
    SW[1] = 1'b0; tick(10);
    chk("bounce_level1", level[1], 0);
    chk("bounce_req1", request[1], 0);
    chk("bounce_arr1", arrivals[15:8], 0);

    // 3. ack handshake
    ack[0] = 1'b1; tick(1); ack[0] = 1'b0;
    chk("ack_req0_cleared", request[0], 0);
    chk("ack_level0_kept", level[0], 1);
    chk("ack_arr0_kept", arrivals[7:0], 1);
    ack[1] = 1'b1; tick(1); ack[1] = 1'b0;
    chk("ack_idle_req1", request[1], 0);
    SW[0] = 1'b0; tick(10);
    chk("release_level0", level[0], 0);
    chk("release_no_req0", request[0], 0);
    SW[0] = 1'b1; tick(7);
    chk("repress_req0", request[0], 1);
    chk("repress_arr0", arrivals[7:0], 2);

    // 4. rise and ack collide on lane 1
    SW[1] = 1'b1; tick(6);
    ack[1] = 1'b1; tick(1); ack[1] = 1'b0;
    chk("collide_req1", request[1], 1);
    chk("collide_level1", level[1], 1);
    chk("collide_arr1", arrivals[15:8], 1);
    ack[1] = 1'b1; tick(1); ack[1] = 1'b0;
    chk("collide_then_ack_req1", request[1], 0);

    // simultaneous presses on both lanes
    SW = 2'b00; tick(10);
    chk("both_released_level", level, 0);
    SW = 2'b11; tick(7);
    chk("both_level", level, 3);
    chk("both_req", request, 3);
    chk("both_arr", arrivals, {8'd2, 8'd3});
    SW = 2'b00; tick(10);
    ack = 2'b11; tick(1); ack = 2'b00;

    // 5. saturation: lane 0 is at 3, so 252 presses reach 255
    for (int i = 0; i < 252; i++) press0_cycle();
    chk("sat_arr0_255", arrivals[7:0], 255);
    for (int i = 0; i < 8; i++) press0_cycle();
    chk("sat_arr0_hold", arrivals[7:0], 255);
    chk("sat_req0", request[0], 1);
    ack[0] = 1'b1; tick(1); ack[0] = 1'b0;
    chk("sat_ack_req0", request[0], 0);
    press0_cycle();
    chk("sat_after_ack_req0", request[0], 1);
    chk("sat_after_ack_arr0", arrivals[7:0], 255);
    chk("sat_arr1_unchanged", arrivals[15:8], 2);

    // 6. reset while lane 0 is in CHECK_HIGH
    SW[0] = 1'b1; tick(4);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_level", level, 0);
    chk("async_rst_req", request, 0);
    chk("async_rst_arr", arrivals, 0);
    tick(2);
    rst = 1'b0;
    tick(6);
    chk("post_rst_edge6_req0", request[0], 0);
    tick(1);
    chk("post_rst_edge7_req0", request[0], 1);
    chk("post_rst_level0", level[0], 1);
    chk("post_rst_arr0", arrivals[7:0], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
